// File: rtl/bcd_serial_adder_if.sv
// Request/result bundle for the digit-serial BCD adder/subtractor.
// The master launches an operation; the slave (the adder) returns the
// packed BCD result together with its status flags.
interface bcd_serial_adder_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic                  sub;
  logic [4*DIGITS-1:0]   in1;
  logic [4*DIGITS-1:0]   in2;
  logic                  carry_in;
  logic [4*DIGITS-1:0]   sum;
  logic                  carry_out;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, sub, in1, in2, carry_in,
    input  sum, carry_out, busy, done, err
  );

  modport slave (
    input  start, sub, in1, in2, carry_in,
    output sum, carry_out, busy, done, err
  );
endinterface

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder/subtractor.
// One decimal digit is resolved per clock, least significant first.
// Subtraction is done as A + nines-complement(B) + 1, so carry_out acts
// as a "no borrow" flag and a negative difference is left in
// ten's-complement form. Operands containing a non-decimal nibble are
// rejected at launch without entering the calculation state.
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  bcd_serial_adder_if.slave bus
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  // True when every nibble of v is a legal decimal digit (0..9).
  function automatic logic all_digits_valid(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // One decimal digit step: returns {carry, digit}.
  // Binary sums 10..19 are corrected by +6 so the nibble wraps into 0..9.
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] a,
                                               input logic [3:0] b,
                                               input logic       c);
    logic [4:0] t;
    t = {1'b0, a} + {1'b0, b} + {4'b0000, c};
    if (t > 5'd9) return {1'b1, t[3:0] + 4'd6};
    else          return {1'b0, t[3:0]};
  endfunction

  state_t          state_q;
  logic [W-1:0]    a_q;        // operand A, shifted right one digit per step
  logic [W-1:0]    b_q;        // operand B, shifted right one digit per step
  logic            sub_q;
  logic            c_q;        // running decimal carry between digits
  logic [IDX_W-1:0] idx_q;     // digit currently being processed
  logic [W-1:0]    acc_q;      // partial result, digits enter at the top
  logic [W-1:0]    sum_q;
  logic            cout_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;
  logic            err_pend_q; // delays the done pulse of a rejected launch

  logic [3:0]      b_eff_d;
  logic [3:0]      dig_d;
  logic            c_d;
  logic [W-1:0]    acc_d;
  logic            start_ok_d;

  // Per-digit datapath for the digit at the bottom of the operand shifters.
  always_comb begin
    b_eff_d    = sub_q ? (4'd9 - b_q[3:0]) : b_q[3:0];
    {c_d, dig_d} = bcd_digit_add(a_q[3:0], b_eff_d, c_q);
    acc_d      = (acc_q >> 4) | (W'(dig_d) << (W - 4));
    start_ok_d = all_digits_valid(bus.in1) && all_digits_valid(bus.in2);
  end

  // Control FSM together with the operand/result registers and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sub_q      <= 1'b0;
      c_q        <= 1'b0;
      idx_q      <= '0;
      acc_q      <= '0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_pend_q <= 1'b0;
    end else begin
      // A rejected launch reports done one cycle after it was seen.
      done_q     <= err_pend_q;
      err_pend_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (start_ok_d) begin
              a_q     <= bus.in1;
              b_q     <= bus.in2;
              sub_q   <= bus.sub;
              // Subtraction always injects the +1 of the ten's complement.
              c_q     <= bus.sub | bus.carry_in;
              idx_q   <= '0;
              acc_q   <= '0;
              err_q   <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= CALC;
            end else begin
              err_q      <= 1'b1;
              sum_q      <= '0;
              cout_q     <= 1'b0;
              err_pend_q <= 1'b1;
            end
          end
        end
        CALC: begin
          a_q   <= a_q >> 4;
          b_q   <= b_q >> 4;
          c_q   <= c_d;
          acc_q <= acc_d;
          idx_q <= idx_q + IDX_ONE;
          // Results are published only once the top digit is resolved.
          if (idx_q == LAST_IDX) begin
            sum_q   <= acc_d;
            cout_q  <= c_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed bench for bcd_serial_adder with a result scoreboard.
module tb_bcd_serial_adder;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int P      = 10 ** DIGITS;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb[$];

  bcd_serial_adder_if #(.DIGITS(DIGITS)) bus ();

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r;
    r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int n);
    logic [W-1:0] v;
    int           k;
    v = '0;
    k = n;
    for (int i = 0; i < DIGITS; i++) begin
      v[4*i +: 4] = 4'(k % 10);
      k = k / 10;
    end
    return v;
  endfunction

  // Reference arithmetic on plain integers.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input logic ci);
    exp_t e;
    bit   bad;
    int   ia, ib, r;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    if (bad) begin
      e.sum = '0; e.cout = 1'b0; e.err = 1'b1; e.lat = 1;
      return e;
    end
    ia = bcd2int(a);
    ib = bcd2int(b);
    if (!s) begin
      r      = ia + ib + (ci ? 1 : 0);
      e.cout = (r >= P);
      r      = r % P;
    end else if (ia >= ib) begin
      r      = ia - ib;
      e.cout = 1'b1;
    end else begin
      r      = P - (ib - ia);
      e.cout = 1'b0;
    end
    e.sum = int2bcd(r);
    e.err = 1'b0;
    e.lat = DIGITS;
    return e;
  endfunction

  task automatic scramble();
    bus.in1      = 16'($urandom);
    bus.in2      = 16'($urandom);
    bus.sub      = 1'($urandom);
    bus.carry_in = 1'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " sum"},  64'(bus.sum), 64'(0));
    check({tag, " cout"}, 64'(bus.carry_out), 64'(0));
    check({tag, " busy"}, 64'(bus.busy), 64'(0));
    check({tag, " done"}, 64'(bus.done), 64'(0));
    check({tag, " err"},  64'(bus.err), 64'(0));
  endtask

  // Called at the sample point right after the start edge; returns at the
  // sample where done is high (or the cycle budget ran out).
  task automatic wait_done(input string tag, input bit poke, output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (!bus.done && lat < 20) begin
      if (bus.busy) bcnt++;
      if (poke && lat == 1) begin
        bus.start = 1'b1;
        bus.in1   = 16'h1111;
        bus.in2   = 16'h2222;
        bus.sub   = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    check({tag, " done_seen"}, 64'(bus.done), 64'(1));
  endtask

  task automatic pop_compare(input string tag, output exp_t e);
    check({tag, " sb_nonempty"}, 64'(sb.size() > 0), 64'(1));
    if (sb.size() > 0) e = sb.pop_front();
    else begin e.sum = '0; e.cout = 1'b0; e.err = 1'b0; e.lat = 0; end
    check({tag, " sum"},  64'(bus.sum), 64'(e.sum));
    check({tag, " cout"}, 64'(bus.carry_out), 64'(e.cout));
    check({tag, " err"},  64'(bus.err), 64'(e.err));
    check({tag, " busy_at_done"}, 64'(bus.busy), 64'(0));
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic ci);
    bus.in1 = a; bus.in2 = b; bus.sub = s; bus.carry_in = ci;
    bus.start = 1'b1;
    sb.push_back(model(a, b, s, ci));
    @(posedge clk); #1;
    bus.start = 1'b0;
    scramble();
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic ci, input bit poke);
    exp_t e;
    int   lat, bcnt;
    launch(a, b, s, ci);
    wait_done(tag, poke, lat, bcnt);
    pop_compare(tag, e);
    check({tag, " latency"}, 64'(lat), 64'(e.lat));
    check({tag, " busy_cycles"}, 64'(bcnt), 64'(e.err ? 0 : DIGITS));
    @(posedge clk); #1;
    check({tag, " done_one_cycle"}, 64'(bus.done), 64'(0));
    check({tag, " sum_hold"}, 64'(bus.sum), 64'(e.sum));
  endtask

  initial begin
    exp_t e;
    int   lat, bcnt, dcnt;

    bus.start = 1'b0;
    scramble();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check_all_zero("post_reset_idle");

    run_op("add_1234_5678",   16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0);
    check("add_1234_5678 literal", 64'(bus.sum), 64'(16'h6912));
    run_op("add_9999_0001",   16'h9999, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op("add_9999_9999_c", 16'h9999, 16'h9999, 1'b0, 1'b1, 1'b0);
    check("add_9999_9999_c literal", 64'(bus.sum), 64'(16'h9999));
    run_op("sub_5000_1234",   16'h5000, 16'h1234, 1'b1, 1'b0, 1'b0);
    check("sub_5000_1234 literal", 64'(bus.sum), 64'(16'h3766));
    run_op("sub_1234_5000",   16'h1234, 16'h5000, 1'b1, 1'b0, 1'b0);
    check("sub_1234_5000 literal", 64'(bus.sum), 64'(16'h6234));
    run_op("sub_cin_ignored", 16'h5000, 16'h1234, 1'b1, 1'b1, 1'b0);
    run_op("sub_equal",       16'h4321, 16'h4321, 1'b1, 1'b0, 1'b0);
    run_op("add_0_0_c",       16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);

    run_op("err_in1",         16'h12A4, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op("valid_clears_err", 16'h0815, 16'h0185, 1'b0, 1'b0, 1'b0);
    run_op("err_in2",         16'h0001, 16'hF000, 1'b1, 1'b0, 1'b0);

    run_op("ignored_start",   16'h1234, 16'h5678, 1'b0, 1'b0, 1'b1);

    // Back-to-back: second start held high in the done cycle of the first.
    launch(16'h2468, 16'h1357, 1'b0, 1'b0);
    wait_done("b2b_first", 1'b0, lat, bcnt);
    pop_compare("b2b_first", e);
    check("b2b_first latency", 64'(lat), 64'(DIGITS));
    bus.in1 = 16'h0100; bus.in2 = 16'h0250; bus.sub = 1'b1; bus.carry_in = 1'b0;
    bus.start = 1'b1;
    sb.push_back(model(16'h0100, 16'h0250, 1'b1, 1'b0));
    @(posedge clk); #1;
    bus.start = 1'b0;
    scramble();
    wait_done("b2b_second", 1'b0, lat, bcnt);
    pop_compare("b2b_second", e);
    check("b2b_second spacing", 64'(lat + 1), 64'(DIGITS + 1));
    @(posedge clk); #1;

    // Reset in the middle of a calculation aborts it silently.
    launch(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("midcalc busy", 64'(bus.busy), 64'(1));
    #2 rst_n = 1'b0;
    #1 check_all_zero("midcalc_reset");
    sb.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.done) dcnt++;
    end
    check("midcalc no_done", 64'(dcnt), 64'(0));
    check("midcalc busy_after", 64'(bus.busy), 64'(0));
    run_op("after_reset_add", 16'h0999, 16'h0001, 1'b0, 1'b0, 1'b0);

    check("scoreboard_empty", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
